serial_alu_ctrl: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_bit_slice.sv | 48 ++++
 rtl/serial_alu_ctrl.sv | 150 +++++++++++++++
 tb/tb_serial_alu_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-serial ALU controller and the 1-bit ALU slice.
//   OP_ADD / OP_AND / OP_CMP / OP_XOR : 2-bit operation encodings, common to the
//                                       controller's op port and the slice's
//                                       aluctr port.
//   ctrl_state_e                      : controller FSM states.
//   usesChain()                       : true for operations whose slice e output
//                                       must be fed back into c on the next bit.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ctrl_state_e;

  // Add carries and compare's greater-than decision both ripple from LSB to MSB
  // through the slice's e -> c path; and/xor are purely bitwise.
  function automatic logic usesChain(input logic [1:0] opSel);
    return (opSel == OP_ADD) || (opSel == OP_CMP);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// -----------------------------------------------------------------------------
// alu_bit_slice
// Combinational 1-bit ALU slice, driven one bit per clock by serial_alu_ctrl.
// Ports:
//   aluctr  in  2  operation select (alu_pkg OP_* encodings)
//   a, b    in  1  operand bits
//   c       in  1  chain input (carry for add, greater-than-so-far for compare)
//   d       out 1  result bit
//   e       out 1  chain output (carry-out for add, greater-than for compare)
// -----------------------------------------------------------------------------
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic [1:0] aluctr,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       d,
  output logic       e
);

  // Compare walks LSB first, so a differing higher bit overrides whatever the
  // lower bits decided; equal bits just pass the lower-order decision along.
  always_comb begin
    d = 1'b0;
    e = 1'b0;
    case (aluctr)
      OP_ADD: begin
        d = a ^ b ^ c;
        e = (a & b) | (a & c) | (b & c);
      end
      OP_AND: begin
        d = a & b;
      end
      OP_CMP: begin
        e = (a != b) ? a : c;
      end
      OP_XOR: begin
        d = a ^ b;
      end
      default: begin
        d = 1'b0;
        e = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// -----------------------------------------------------------------------------
// serial_alu_ctrl
// Bit-serial sequencer that runs a WIDTH-bit operation through an external
// combinational 1-bit ALU slice, LSB first, one bit per clock.
// Ports:
//   clk, rst         clock (rising edge) and asynchronous active-high reset
//   start            operation request, only sampled while idle
//   op, in_a, in_b   operation and operands, latched on the start edge
//   cin              carry-in for add, latched on the start edge
//   busy             high while an operation is in progress or completing
//   done             one-cycle pulse, result/flag valid from this cycle on
//   result, flag     assembled result word; carry-out (add) or a>b (compare)
//   alu_ctr/a/b/c    drive to the slice, all zero outside the run phase
//   alu_d, alu_e     same-cycle slice outputs
// Timing: start sampled at edge 0, bits captured on edges 1..WIDTH, done is
// high in the cycle after edge WIDTH, then back to idle unconditionally.
// -----------------------------------------------------------------------------
module serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag,
  output logic [1:0]       alu_ctr,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_c,
  input  logic             alu_d,
  input  logic             alu_e
);

  // Exit compare is against the last bit index rather than relying on the
  // counter wrapping, so non-power-of-two widths terminate correctly.
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  ctrl_state_e      state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             chain_q, chain_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_q, flag_d;

  // All state lives here; reset aborts any operation in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      chain_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      chain_q  <= chain_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  // Next-state and slice drive. The slice is only driven during RUN so the
  // parent sees a quiet, X-free bus whenever no operation is in progress.
  // The final bit is folded into acc_d before it is copied to result_d so the
  // result register updates on the same edge that captures the last bit.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    chain_d  = chain_q;
    acc_d    = acc_q;
    result_d = result_q;
    flag_d   = flag_q;
    alu_ctr  = 2'b00;
    alu_a    = 1'b0;
    alu_b    = 1'b0;
    alu_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = in_a;
          b_d     = in_b;
          idx_d   = '0;
          acc_d   = '0;
          chain_d = (op == OP_ADD) ? cin : 1'b0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        alu_ctr = op_q;
        alu_a   = a_q[idx_q];
        alu_b   = b_q[idx_q];
        alu_c   = usesChain(op_q) ? chain_q : 1'b0;

        acc_d[idx_q] = alu_d;
        if (usesChain(op_q)) begin
          chain_d = alu_e;
        end

        if (idx_q == LAST_IDX) begin
          idx_d    = '0;
          result_d = acc_d;
          flag_d   = usesChain(op_q) ? alu_e : 1'b0;
          state_d  = ST_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy   = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign flag   = flag_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_alu_ctrl
// Self-checking bench for serial_alu_ctrl with an alu_bit_slice attached.
// Expected results come from plain integer arithmetic on whole operands.
// -----------------------------------------------------------------------------
module tb_serial_alu_ctrl;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         flag;
  logic [1:0]   alu_ctr;
  logic         alu_a;
  logic         alu_b;
  logic         alu_c;
  logic         alu_d;
  logic         alu_e;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int sliceErr = 0;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .in_a   (in_a),
    .in_b   (in_b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flag   (flag),
    .alu_ctr(alu_ctr),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_c  (alu_c),
    .alu_d  (alu_d),
    .alu_e  (alu_e)
  );

  alu_bit_slice slice (
    .aluctr(alu_ctr),
    .a     (alu_a),
    .b     (alu_b),
    .c     (alu_c),
    .d     (alu_d),
    .e     (alu_e)
  );

  // Free-running clock and a cycle counter used to measure operation period.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: whole-word result of the operation.
  function automatic logic [W-1:0] refResult(input logic [1:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic ci);
    int s;
    s = int'(a) + int'(b) + int'(ci);
    case (o)
      OP_ADD:  return s[W-1:0];
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Reference: carry-out for add, unsigned a>b for compare.
  function automatic logic refFlag(input logic [1:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic ci);
    int s;
    s = int'(a) + int'(b) + int'(ci);
    case (o)
      OP_ADD:  return s > ((1 << W) - 1);
      OP_CMP:  return a > b;
      default: return 1'b0;
    endcase
  endfunction

  // Reference: chain value presented to the slice while bit k is processed,
  // derived from the low k bits of the operands as whole numbers.
  function automatic logic chainIn(input logic [1:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic ci, input int k);
    int mask;
    int s;
    mask = (1 << k) - 1;
    s    = (int'(a) & mask) + (int'(b) & mask) + int'(ci);
    case (o)
      OP_ADD:  return ((s >> k) & 1) == 1;
      OP_CMP:  return (int'(a) & mask) > (int'(b) & mask);
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Issues one operation and follows it to done, checking the slice drive on
  // every RUN cycle. Inputs are scrambled right after the start edge to show
  // only the latched copies are used. Optionally pulses start mid-run.
  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic ci, input bit midPulse, output int lat);
    @(negedge clk);
    op = o; in_a = a; in_b = b; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom); in_a = W'($urandom); in_b = W'($urandom); cin = 1'($urandom);
    lat = 0;
    sliceErr = 0;
    while (!done && lat < 40) begin
      if (lat < W) begin
        if (busy !== 1'b1 || alu_ctr !== o || alu_a !== a[lat] || alu_b !== b[lat] ||
            alu_c !== chainIn(o, a, b, ci, lat))
          sliceErr++;
      end
      start = (midPulse && lat == 3) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  // Runs one operation and checks latency, result, flag and the done pulse.
  task automatic runOp(input string name, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ci, input bit midPulse);
    int lat;
    int extra;
    applyStimulus(o, a, b, ci, midPulse, lat);
    checkOutput({name, " latency"}, 32'(lat), 32'(W));
    checkOutput({name, " result"}, 32'(result), 32'(refResult(o, a, b, ci)));
    checkOutput({name, " flag"}, 32'(flag), 32'(refFlag(o, a, b, ci)));
    checkOutput({name, " busy at done"}, 32'(busy), 32'd1);
    checkOutput({name, " slice drive"}, 32'(sliceErr), 32'd0);
    @(posedge clk); #1;
    checkOutput({name, " done width"}, 32'(done), 32'd0);
    checkOutput({name, " idle busy"}, 32'(busy), 32'd0);
    if (midPulse) begin
      extra = 0;
      repeat (12) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      checkOutput({name, " extra done"}, 32'(extra), 32'd0);
      checkOutput({name, " result held"}, 32'(result), 32'(refResult(o, a, b, ci)));
    end
  endtask

  initial begin
    logic [1:0]   bo;
    logic [W-1:0] ba;
    logic [W-1:0] bb;
    logic         bc;
    int           n;
    int           prevCyc;
    int           seenDone;

    rst = 1'b1; start = 1'b0; op = 2'b00; in_a = '0; in_b = '0; cin = 1'b0;
    prevCyc = 0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset result", 32'(result), 32'd0);
    checkOutput("reset flag", 32'(flag), 32'd0);
    checkOutput("reset slice", 32'({alu_ctr, alu_a, alu_b, alu_c}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed operations.
    runOp("add ff+01", OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0);
    runOp("add 3c+5a+1", OP_ADD, 8'h3C, 8'h5A, 1'b1, 1'b0);
    runOp("and f0&3c", OP_AND, 8'hF0, 8'h3C, 1'b1, 1'b0);
    runOp("cmp 80>7f", OP_CMP, 8'h80, 8'h7F, 1'b1, 1'b0);
    runOp("cmp 55>55", OP_CMP, 8'h55, 8'h55, 1'b0, 1'b0);
    runOp("cmp 01>02", OP_CMP, 8'h01, 8'h02, 1'b0, 1'b0);
    runOp("xor a5^ff busy-start", OP_XOR, 8'hA5, 8'hFF, 1'b0, 1'b1);

    // Reset four cycles into RUN aborts the operation.
    @(negedge clk);
    op = OP_ADD; in_a = 8'h12; in_b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort pre busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort result", 32'(result), 32'd0);
    checkOutput("abort flag", 32'(flag), 32'd0);
    checkOutput("abort slice", 32'({alu_ctr, alu_a, alu_b, alu_c}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seenDone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seenDone++;
    end
    checkOutput("abort no done", 32'(seenDone), 32'd0);
    runOp("add 12+34 after abort", OP_ADD, 8'h12, 8'h34, 1'b0, 1'b0);

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 20; i++) begin
      runOp($sformatf("rand%0d", i), 2'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    end

    // Back-to-back with start held high: new inputs are presented during DONE.
    @(negedge clk);
    bo = 2'($urandom); ba = W'($urandom); bb = W'($urandom); bc = 1'($urandom);
    op = bo; in_a = ba; in_b = bb; cin = bc; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!done && n < 40);
      checkOutput($sformatf("b2b%0d done", i), 32'(done), 32'd1);
      checkOutput($sformatf("b2b%0d result", i), 32'(result), 32'(refResult(bo, ba, bb, bc)));
      checkOutput($sformatf("b2b%0d flag", i), 32'(flag), 32'(refFlag(bo, ba, bb, bc)));
      if (i > 0) checkOutput($sformatf("b2b%0d period", i), 32'(cyc - prevCyc), 32'(W + 2));
      prevCyc = cyc;
      bo = 2'($urandom); ba = W'($urandom); bb = W'($urandom); bc = 1'($urandom);
      op = bo; in_a = ba; in_b = bb; cin = bc;
      if (i == 3) start = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("final idle busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
